ads62p44_spi_rx: RTL



---
 rtl/ads62p44_spi_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ads62p44_spi_rx.sv
// ADS62P44 serial-interface responder: decodes 16-bit address/data frames into a shadow register file.
// Define ADS62P44_SPI_RX_READOUT_EN to build the serial readout path on sdout.

module ads62p44_spi_rx #(
    parameter int ERR_W = 8,
    parameter int FRM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csb,
    input  logic             sdio,
    output logic             sdout,
    output logic             frame_valid,
    output logic [7:0]       frame_addr,
    output logic [7:0]       frame_data,
    output logic [2:0]       adcmode,
    output logic             readout_en,
    input  logic [7:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic [FRM_W-1:0] frame_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, OVERRUN} state_t;
    localparam int NREG = 13;

    state_t      state, state_nx;
    logic [14:0] shift_q;
    logic [4:0]  bit_cnt;
    logic        extra_q;
    logic        frame_err_q;
    logic [7:0]  regs [NREG];

    // Returns {hit, index} for the thirteen mirrored ADC registers.
    function automatic logic [4:0] map_addr(input logic [7:0] a);
        logic [4:0] m;
        m = 5'd0;
        case (a)
            8'h00: m = {1'b1, 4'd0};
            8'h10: m = {1'b1, 4'd1};
            8'h11: m = {1'b1, 4'd2};
            8'h12: m = {1'b1, 4'd3};
            8'h13: m = {1'b1, 4'd4};
            8'h14: m = {1'b1, 4'd5};
            8'h16: m = {1'b1, 4'd6};
            8'h17: m = {1'b1, 4'd7};
            8'h18: m = {1'b1, 4'd8};
            8'h19: m = {1'b1, 4'd9};
            8'h1A: m = {1'b1, 4'd10};
            8'h1B: m = {1'b1, 4'd11};
            8'h1D: m = {1'b1, 4'd12};
            default: m = 5'd0;
        endcase
        return m;
    endfunction

    logic       last_bit, is_read, commit_bad, err_inc;
    logic [7:0] commit_addr, commit_data;
    logic [4:0] commit_map, rd_map;

    assign last_bit    = (state == SHIFT) && !csb && (bit_cnt == 5'd15);
    assign commit_addr = shift_q[14:7];
    assign commit_data = {shift_q[6:0], sdio};
    assign commit_map  = map_addr(commit_addr);
    assign rd_map      = map_addr(rd_addr);
    assign is_read     = readout_en && (commit_addr != 8'h00);
    assign commit_bad  = !is_read && !commit_map[4];
    // One error per frame: an overrun after an unmapped write is not counted again.
    assign err_inc     = ((state == SHIFT) && csb)
                       || (last_bit && commit_bad)
                       || ((state == OVERRUN) && csb && extra_q && !frame_err_q);

    assign adcmode    = regs[6][2:0];
    assign readout_en = regs[0][0];

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        // NOTE: default assignment first so no branch leaves state_nx unassigned and infers a latch.
        state_nx = state;
        case (state)
            IDLE:    if (!csb) state_nx = SHIFT;
            SHIFT:   if (csb) state_nx = IDLE;
                     else if (bit_cnt == 5'd15) state_nx = COMMIT;
            COMMIT:  state_nx = csb ? IDLE : OVERRUN;
            OVERRUN: if (csb) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        frame_valid = (state == COMMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            extra_q     <= 1'b0;
            frame_err_q <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
            // NOTE: the shadow array is reset because it mirrors registers that power up as 0x00.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (state == IDLE) begin
                extra_q     <= 1'b0;
                frame_err_q <= 1'b0;
                if (!csb) begin
                    shift_q <= {14'd0, sdio};
                    bit_cnt <= 5'd1;
                end
            end else if (state == SHIFT && !csb) begin
                shift_q <= {shift_q[13:0], sdio};
                bit_cnt <= bit_cnt + 5'd1;
            end else if ((state == COMMIT || state == OVERRUN) && !csb) begin
                extra_q <= 1'b1;
            end

            if (last_bit) begin
                frame_addr  <= commit_addr;
                frame_data  <= commit_data;
                frame_cnt   <= frame_cnt + FRM_W'(1);
                frame_err_q <= commit_bad;
                if (!is_read) begin
                    if (commit_addr == 8'h00 && commit_data[1]) begin
                        for (int i = 0; i < NREG; i++) regs[i] <= '0;
                    end else if (commit_map[4]) begin
                        regs[commit_map[3:0]] <= commit_data;
                    end
                end
            end

            if (err_inc && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= rd_map[4] ? regs[rd_map[3:0]] : 8'h00;
    end

`ifdef ADS62P44_SPI_RX_READOUT_EN
    logic [4:0] ro_map;
    logic [7:0] ro_val;
    logic [7:0] ro_buf;
    logic       sdout_q;

    assign ro_map = map_addr({shift_q[6:0], sdio});
    assign ro_val = ro_map[4] ? regs[ro_map[3:0]] : 8'h00;

    // Bit 7 leaves on the sample that completes the address, then one bit per low-csb edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdout_q <= 1'b0;
            ro_buf  <= '0;
        end else if (state == SHIFT && !csb && bit_cnt == 5'd7) begin
            sdout_q <= readout_en & ro_val[7];
            ro_buf  <= {ro_val[6:0], 1'b0};
        end else if (state == SHIFT && !csb && bit_cnt >= 5'd8 && bit_cnt <= 5'd14) begin
            sdout_q <= readout_en & ro_buf[7];
            ro_buf  <= {ro_buf[6:0], 1'b0};
        end else begin
            sdout_q <= 1'b0;
        end
    end

    assign sdout = sdout_q & ~csb;
`else
    assign sdout = 1'b0;
`endif

endmodule
